cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Consumer end of the functional-unit valid/yumi result handshake.
//  Each cycle, selects at most one pending result from NUM_FU execute units (add/sub, mul, load, ...).
//  Acknowledges the winner with a one-cycle yumi and broadcasts its CDB_packet_t on the common data bus.
//  The broadcast comes from a registered output stage and goes to the ROB and the reservation stations.
// PARAMETERS
//  NUM_FU   4  number of functional units competing for the CDB (>=2)
//  PTR_W    $clog2(NUM_FU)  width of the round-robin pointer (derived, do not override)
// PORTS
//  clk           in   1               clock
//  reset         in   1               synchronous, active-high reset
//  flush         in   1               mispredict squash; kills the in-flight broadcast
//  fu_valid_in   in   NUM_FU          FU i holds a result; stays high until yumi
//  fu_packet_in  in   NUM_FU x pkt    CDB_packet_t per FU; stable while valid
//  fu_yumi_out   out  NUM_FU          one-hot accept; FU i drops valid next cycle
//  cdb_ready_in  in   1               ROB can absorb a broadcast this cycle
//  cdb_valid_out out  1               cdb_out holds a live broadcast
//  cdb_out       out  pkt             {result[31:0], dest_ROB_entry[3:0], branch_result, load_step1}
// BEHAVIOUR
//  - Reset values: cdb_valid_out=0, cdb_out='0, rr_ptr=0. fu_yumi_out=0 during the reset cycle.
//  - can_load = ~cdb_valid_out | cdb_ready_in. This is an output register with a bubble-free handshake.
//  - Grant is combinational: the first i with fu_valid_in[i], scanning from rr_ptr upward, mod NUM_FU.
//  - fu_yumi_out = onehot(grant) & {NUM_FU{can_load & ~flush & ~reset & any_valid}}.
//  - fu_yumi_out is never asserted for an FU whose valid is low. It is never more than one-hot.
//  - On a yumi cycle: cdb_out <= fu_packet_in[grant]; cdb_valid_out <= 1; rr_ptr <= grant+1, wrapping NUM_FU-1 -> 0.
//  - Latency: FU valid to cdb_valid_out is 1 cycle when uncontended and the output is free.
//  - Broadcast consumed (valid & ready) with no new grant: cdb_valid_out <= 0; cdb_out holds its old value.
//  - cdb_valid_out=1 and cdb_ready_in=0: cdb_out/cdb_valid_out stay bit-stable, all yumi=0, rr_ptr holds.
//  - Consume and new grant in the same cycle: back-to-back broadcasts with no bubble.
//  - No FU valid: rr_ptr holds and no yumi is issued.
//  - flush has priority over everything except reset:
//    - next cycle cdb_valid_out=0;
//    - yumi=0 that cycle;
//    - rr_ptr holds;
//    - cdb_out data is don't-care but held.
//  - reset mid-broadcast: the pending packet is dropped. The FUs are reset by the same signal.
//  - Fairness: any continuously-valid FU is granted within NUM_FU grant cycles.
//  - The arbiter never modifies packet fields. branch_result and load_step1 pass through unchanged.
// STRUCTURE
//  - Shared package (structs.sv):
//    - CDB_packet_t;
//    - NUM_FU_DEFAULT;
//    - the FU index enum (FU_ADD, FU_MUL, FU_LD, FU_BR).
//  - Sub-module rr_pick: combinational round-robin priority picker.
//    - ports: req[NUM_FU], ptr[PTR_W] -> gnt_onehot, gnt_idx, any.
//    - implemented as a double-width request vector with a masked priority encode.
//  - Top level: can_load logic, yumi gating, output register, rr_ptr register.
// TESTING
//  1. FU2 valid with result=0x12345678, rob=5, others idle, ready=1.
//     -> yumi=4'b0100 that cycle; next cycle cdb_valid=1 with the packet; rr_ptr=3.
//  2. All 4 FUs held valid, ready=1 -> grant order 0,1,2,3,0; one broadcast every cycle; no gaps.
//  3. Output valid, ready=0 for 3 cycles with FU1 valid.
//     -> cdb_out stable and yumi=0 throughout.
//     -> the cycle ready rises, yumi[1]=1; next cycle FU1's packet appears.
//  4. rr_ptr=3, FU1 and FU3 valid -> grant FU3 first (wrap), then FU1; rr_ptr ends at 2.
//  5. flush with FU0 valid and output valid -> yumi=0; next cycle cdb_valid=0; FU0 granted the following cycle.
//  6. reset asserted mid-stream -> next cycle cdb_valid=0, cdb_out=0, rr_ptr=0; first grant after reset goes to the lowest valid FU.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: the broadcast packet layout,
// the default functional-unit count and the functional-unit index names.
package cdb_arbiter_pkg;

    localparam int NUM_FU_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  dest_ROB_entry;
        logic        branch_result;
        logic        load_step1;
    } CDB_packet_t;

    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_MUL = 2'd1,
        FU_LD  = 2'd2,
        FU_BR  = 2'd3
    } fu_idx_e;

    // Round-robin successor of idx among n slots, wrapping n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshake from the functional units plus the broadcast bus toward the ROB.
// master = FU/ROB side, slave = the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
) ();

    logic [NUM_FU-1:0] fu_valid_in;
    CDB_packet_t       fu_packet_in [NUM_FU];
    logic [NUM_FU-1:0] fu_yumi_out;
    logic              cdb_ready_in;
    logic              cdb_valid_out;
    CDB_packet_t       cdb_out;

    modport master (
        output fu_valid_in,
        output fu_packet_in,
        output cdb_ready_in,
        input  fu_yumi_out,
        input  cdb_valid_out,
        input  cdb_out
    );

    modport slave (
        input  fu_valid_in,
        input  fu_packet_in,
        input  cdb_ready_in,
        output fu_yumi_out,
        output cdb_valid_out,
        output cdb_out
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr, wrapping,
// found by a priority encode over a doubled request vector with the low part masked.
module cdb_arbiter_rr_pick #(
    parameter  int NUM_FU = 4,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_FU-1:0] gnt_onehot,
    output logic [PTR_W-1:0]  gnt_idx,
    output logic              any
);

    logic [2*NUM_FU-1:0] dbl_s;
    logic [2*NUM_FU-1:0] masked_s;
    logic                hit_s;

    // Suppress requests below ptr in the lower copy; the upper copy supplies the wrap.
    always_comb begin
        dbl_s    = {req, req};
        masked_s = '0;
        for (int j = 0; j < 2 * NUM_FU; j++) begin
            if (j >= int'(ptr)) begin
                masked_s[j] = dbl_s[j];
            end else begin
                masked_s[j] = 1'b0;
            end
        end
    end

    // Lowest set bit of the masked vector wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        hit_s      = 1'b0;
        for (int j = 0; j < 2 * NUM_FU; j++) begin
            if (masked_s[j] && !hit_s) begin
                hit_s      = 1'b1;
                gnt_idx    = PTR_W'(j % NUM_FU);
                gnt_onehot = NUM_FU'(1'b1) << (j % NUM_FU);
            end else begin
                hit_s = hit_s;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among FU results, one-hot yumi
// acknowledge, and a single registered broadcast stage toward the ROB/RS.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_FU = NUM_FU_DEFAULT,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [PTR_W-1:0]  gnt_idx_s;
    logic [NUM_FU-1:0] gnt_onehot_s;
    logic              any_s;
    logic              can_load_s;
    logic              grant_en_s;
    logic              cdb_valid_r;
    CDB_packet_t       cdb_pkt_r;

    cdb_arbiter_rr_pick #(
        .NUM_FU (NUM_FU)
    ) u_rr_pick (
        .req        (bus.fu_valid_in),
        .ptr        (rr_ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any        (any_s)
    );

    // The output stage can take a new packet if empty or being drained this cycle.
    always_comb begin
        can_load_s = ~cdb_valid_r | bus.cdb_ready_in;
        grant_en_s = can_load_s & ~flush & ~reset & any_s;
        ptr_nxt_s  = PTR_W'(rr_next(int'(gnt_idx_s), NUM_FU));
    end

    assign bus.fu_yumi_out   = gnt_onehot_s & {NUM_FU{grant_en_s}};
    assign bus.cdb_valid_out = cdb_valid_r;
    assign bus.cdb_out       = cdb_pkt_r;

    // Broadcast register and round-robin pointer; flush drops the valid but keeps data and pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_r <= 1'b0;
            cdb_pkt_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (flush) begin
            cdb_valid_r <= 1'b0;
        end else if (grant_en_s) begin
            cdb_pkt_r   <= bus.fu_packet_in[gnt_idx_s];
            cdb_valid_r <= 1'b1;
            rr_ptr_r    <= ptr_nxt_s;
        end else if (bus.cdb_ready_in) begin
            cdb_valid_r <= 1'b0;
        end else begin
            cdb_valid_r <= cdb_valid_r;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: yumi and state are checked per cycle, while a
// monitor checks every consumed broadcast against a queue of expected packets.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    int          n_checks = 0;
    int          n_errors = 0;
    CDB_packet_t pk [N];
    CDB_packet_t exp_q [$];

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs already set at negedge; check yumi, record expected broadcast, advance.
    task automatic cyc(input logic [N-1:0] exp_yumi, input string name);
        logic [N-1:0] y;
        #1;
        y = bus.fu_yumi_out;
        chk({name, "_yumi"}, 64'(y), 64'(exp_yumi));
        for (int i = 0; i < N; i++) begin
            if (exp_yumi[i]) exp_q.push_back(pk[i]);
        end
        @(negedge clk);
        bus.fu_valid_in = bus.fu_valid_in & ~y;
    endtask

    task automatic chk_state(input logic exp_valid, input int exp_ptr, input string name);
        chk({name, "_valid"}, 64'(bus.cdb_valid_out), 64'(exp_valid));
        chk({name, "_ptr"}, 64'(dut.rr_ptr_r), 64'(exp_ptr));
    endtask

    task automatic chk_data(input CDB_packet_t exp, input string name);
        chk({name, "_data"}, 64'(bus.cdb_out), 64'(exp));
    endtask

    // Monitor: every broadcast accepted by the ROB must match the next expected packet.
    always begin
        CDB_packet_t e;
        @(negedge clk);
        #2;
        if (reset === 1'b0 && bus.cdb_valid_out === 1'b1 && bus.cdb_ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL bcast_unexpected: got %0h expected no broadcast", bus.cdb_out);
            end else begin
                e = exp_q.pop_front();
                chk("bcast", 64'(bus.cdb_out), 64'(e));
            end
        end
    end

    initial begin
        logic [N-1:0] t2_yumi [5];
        int           t2_ptr  [5];

        pk[int'(FU_ADD)] = '{result: 32'hA000_0000, dest_ROB_entry: 4'd1, branch_result: 1'b1, load_step1: 1'b0};
        pk[int'(FU_MUL)] = '{result: 32'hB111_1111, dest_ROB_entry: 4'd2, branch_result: 1'b0, load_step1: 1'b1};
        pk[int'(FU_LD)]  = '{result: 32'h1234_5678, dest_ROB_entry: 4'd5, branch_result: 1'b0, load_step1: 1'b0};
        pk[int'(FU_BR)]  = '{result: 32'hDDDD_0003, dest_ROB_entry: 4'd9, branch_result: 1'b1, load_step1: 1'b1};
        for (int i = 0; i < N; i++) bus.fu_packet_in[i] = pk[i];

        t2_yumi = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t2_ptr  = '{1, 2, 3, 0, 1};

        // Reset: yumi gated even with every FU valid
        reset = 1'b1;
        flush = 1'b0;
        bus.fu_valid_in  = 4'b1111;
        bus.cdb_ready_in = 1'b1;
        cyc(4'b0000, "rst_gate");
        bus.fu_valid_in = 4'b0000;
        cyc(4'b0000, "rst_hold");
        chk_state(1'b0, 0, "rst");
        chk_data('0, "rst");

        // 1: lone FU2 result, one-cycle latency
        reset = 1'b0;
        bus.fu_valid_in = 4'b0100;
        cyc(4'b0100, "t1");
        chk_state(1'b1, 3, "t1");
        chk_data(pk[2], "t1");
        cyc(4'b0000, "t1_idle");
        chk_state(1'b0, 3, "t1_idle");
        chk_data(pk[2], "t1_idle");

        // 2: all FUs held valid, pointer first brought to 0
        bus.fu_valid_in = 4'b1000;
        cyc(4'b1000, "t2_warm");
        chk_state(1'b1, 0, "t2_warm");
        for (int k = 0; k < 5; k++) begin
            bus.fu_valid_in = 4'b1111;
            cyc(t2_yumi[k], $sformatf("t2_g%0d", k));
            chk_state(1'b1, t2_ptr[k], $sformatf("t2_g%0d", k));
        end
        bus.fu_valid_in = 4'b0000;
        cyc(4'b0000, "t2_drain");
        chk_state(1'b0, 1, "t2_drain");

        // 3: backpressure holds the output and blocks FU1
        bus.fu_valid_in = 4'b0001;
        cyc(4'b0001, "t3_load");
        chk_state(1'b1, 1, "t3_load");
        bus.fu_valid_in  = 4'b0010;
        bus.cdb_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0000, $sformatf("t3_stall%0d", k));
            chk_state(1'b1, 1, $sformatf("t3_stall%0d", k));
            chk_data(pk[0], $sformatf("t3_stall%0d", k));
        end
        bus.cdb_ready_in = 1'b1;
        cyc(4'b0010, "t3_release");
        chk_state(1'b1, 2, "t3_release");
        chk_data(pk[1], "t3_release");
        cyc(4'b0000, "t3_drain");

        // 4: wrap from pointer 3 with FU1 and FU3 requesting
        bus.fu_valid_in = 4'b0100;
        cyc(4'b0100, "t4_setup");
        chk_state(1'b1, 3, "t4_setup");
        bus.fu_valid_in = 4'b1010;
        cyc(4'b1000, "t4_wrap");
        chk_state(1'b1, 0, "t4_wrap");
        cyc(4'b0010, "t4_second");
        chk_state(1'b1, 2, "t4_second");
        chk_data(pk[1], "t4_second");
        cyc(4'b0000, "t4_drain");

        // 5: flush kills the live broadcast and blocks FU0 for one cycle
        bus.fu_valid_in = 4'b0100;
        cyc(4'b0100, "t5_setup");
        flush = 1'b1;
        bus.cdb_ready_in = 1'b0;
        bus.fu_valid_in  = 4'b0001;
        cyc(4'b0000, "t5_flush");
        exp_q.delete();
        chk_state(1'b0, 3, "t5_flush");
        flush = 1'b0;
        bus.cdb_ready_in = 1'b1;
        cyc(4'b0001, "t5_after");
        chk_state(1'b1, 1, "t5_after");
        chk_data(pk[0], "t5_after");
        cyc(4'b0000, "t5_drain");

        // 6: reset mid-stream, then lowest valid FU wins
        bus.fu_valid_in = 4'b0100;
        cyc(4'b0100, "t6_setup");
        reset = 1'b1;
        bus.cdb_ready_in = 1'b0;
        bus.fu_valid_in  = 4'b1111;
        cyc(4'b0000, "t6_rst");
        exp_q.delete();
        chk_state(1'b0, 0, "t6_rst");
        chk_data('0, "t6_rst");
        reset = 1'b0;
        bus.cdb_ready_in = 1'b1;
        bus.fu_valid_in  = 4'b1010;
        cyc(4'b0010, "t6_first");
        chk_state(1'b1, 2, "t6_first");
        chk_data(pk[1], "t6_first");
        cyc(4'b1000, "t6_next");
        chk_state(1'b1, 0, "t6_next");
        cyc(4'b0000, "t6_drain");
        chk_state(1'b0, 0, "t6_drain");

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
